// File: rtl/alu_operand_stage.sv
// Single-entry ID/EX register in front of the ALU: captures decoded operands,
// forwards MEM/WB results onto them and hands SrcA/SrcB/ALUControl over valid/ready.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [REGW-1:0] in_rs1_addr,
  input  logic [REGW-1:0] in_rs2_addr,
  input  logic [REGW-1:0] in_rd_addr,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [2:0]      in_alu_control,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            fwd_mem_valid,
  input  logic            fwd_wb_valid,
  input  logic [REGW-1:0] fwd_mem_rd,
  input  logic [REGW-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  output logic [REGW-1:0] out_rd_addr,
  output logic            out_reg_write
);

  logic            vld_p1;
  logic [XLEN-1:0] rs1_val_p1;
  logic [XLEN-1:0] rs2_val_p1;
  logic [REGW-1:0] rs1_addr_p1;
  logic [REGW-1:0] rs2_addr_p1;
  logic [REGW-1:0] rd_p1;
  logic [XLEN-1:0] imm_p1;
  logic            alu_src_p1;
  logic [2:0]      alu_control_p1;
  logic            reg_write_p1;
  logic            load;
  logic            hold;

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REGW-1:0] a,
    input logic [XLEN-1:0] v,
    input logic            mem_vld,
    input logic [REGW-1:0] mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_vld,
    input logic [REGW-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (mem_vld && (mem_rd == a) && (a != '0))
      return mem_data;
    else if (wb_vld && (wb_rd == a) && (a != '0))
      return wb_data;
    else
      return v;
  endfunction

  assign in_ready = !vld_p1 || out_ready;
  assign load     = in_valid && in_ready && !flush;
  assign hold     = vld_p1 && !out_ready;

  // p0 -> p1: decode into the entry; while stalled, stored operands absorb forwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1         <= 1'b0;
      rs1_val_p1     <= '0;
      rs2_val_p1     <= '0;
      rs1_addr_p1    <= '0;
      rs2_addr_p1    <= '0;
      rd_p1          <= '0;
      imm_p1         <= '0;
      alu_src_p1     <= 1'b0;
      alu_control_p1 <= 3'b000;
      reg_write_p1   <= 1'b0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (load)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;

      if (load) begin
        rs1_val_p1     <= fwd_sel(in_rs1_addr, in_rs1_data, fwd_mem_valid, fwd_mem_rd,
                                  fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs2_val_p1     <= fwd_sel(in_rs2_addr, in_rs2_data, fwd_mem_valid, fwd_mem_rd,
                                  fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs1_addr_p1    <= in_rs1_addr;
        rs2_addr_p1    <= in_rs2_addr;
        rd_p1          <= in_rd_addr;
        imm_p1         <= in_imm;
        alu_src_p1     <= in_alu_src;
        alu_control_p1 <= in_alu_control;
        reg_write_p1   <= in_reg_write;
      end else if (hold) begin
        rs1_val_p1 <= fwd_sel(rs1_addr_p1, rs1_val_p1, fwd_mem_valid, fwd_mem_rd,
                              fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs2_val_p1 <= fwd_sel(rs2_addr_p1, rs2_val_p1, fwd_mem_valid, fwd_mem_rd,
                              fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
      end
    end
  end

  // p1 -> ALU: operands see the live forward buses in the same cycle
  always_comb begin
    SrcA = fwd_sel(rs1_addr_p1, rs1_val_p1, fwd_mem_valid, fwd_mem_rd,
                   fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    if (alu_src_p1)
      SrcB = imm_p1;
    else
      SrcB = fwd_sel(rs2_addr_p1, rs2_val_p1, fwd_mem_valid, fwd_mem_rd,
                     fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
  end

  assign out_valid     = vld_p1;
  assign ALUControl    = alu_control_p1;
  assign out_rd_addr   = rd_p1;
  assign out_reg_write = vld_p1 && reg_write_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, streaming, immediate select,
// forwarding priority, stall refresh, flush and asynchronous reset mid-hold.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_imm;
  logic        in_alu_src;
  logic [2:0]  in_alu_control;
  logic        in_reg_write;
  logic        flush;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_control(in_alu_control),
    .in_reg_write(in_reg_write), .flush(flush),
    .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] rd,
                       input logic src, input logic [31:0] imm);
    in_valid       = 1'b1;
    in_alu_control = ctl;
    in_rs1_addr    = a1;
    in_rs1_data    = d1;
    in_rs2_addr    = a2;
    in_rs2_data    = d2;
    in_rd_addr     = rd;
    in_alu_src     = src;
    in_imm         = imm;
    in_reg_write   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    fwd_mem_rd = '0; fwd_wb_rd = '0; fwd_mem_data = '0; fwd_wb_data = '0;
    drive(3'b011, 5'd1, 32'h1234, 5'd2, 32'h5678, 5'd9, 1'b0, 32'h0);

    // Reset held three cycles with in_valid asserted
    repeat (3) tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_srca", SrcA, 32'd0);
    check("rst_srcb", SrcB, 32'd0);
    check("rst_aluctl", {29'b0, ALUControl}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_reg_write", {31'b0, out_reg_write}, 32'd0);
    rst_n = 1'b1;

    // Streaming add/sub/and/or, first load visible one cycle after acceptance
    drive(3'b000, 5'd1, 32'd5, 5'd2, 32'd3, 5'd7, 1'b0, 32'h0);
    #1;
    check("pre_load_out_valid", {31'b0, out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stream_out_valid", {31'b0, out_valid}, 32'd1);
      check("stream_aluctl", {29'b0, ALUControl}, k);
      check("stream_srca", SrcA, 32'd5);
      check("stream_srcb", SrcB, 32'd3);
      check("stream_in_ready", {31'b0, in_ready}, 32'd1);
      in_alu_control = 3'(k + 1);
    end
    check("stream_rd", {27'b0, out_rd_addr}, 32'd7);
    check("stream_reg_write", {31'b0, out_reg_write}, 32'd1);

    // Immediate selected: forward on rs2 must not reach SrcB
    drive(3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd8, 1'b1, 32'hFFFF_FFFC);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd2; fwd_mem_data = 32'h55;
    tick();
    check("imm_srcb", SrcB, 32'hFFFF_FFFC);
    check("imm_srca", SrcA, 32'd5);

    // MEM beats WB on the same register
    drive(3'b001, 5'd4, 32'h1, 5'd7, 32'd3, 5'd8, 1'b0, 32'h0);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h11;
    fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd4; fwd_wb_data  = 32'h22;
    tick();
    check("prio_srca_mem", SrcA, 32'h11);
    check("prio_srcb", SrcB, 32'd3);
    fwd_mem_valid = 1'b0;
    #1;
    check("prio_srca_wb", SrcA, 32'h22);

    // Register 0 never forwarded
    drive(3'b010, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 1'b0, 32'h0);
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h99;
    fwd_wb_valid  = 1'b1; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'h99;
    tick();
    check("x0_srca", SrcA, 32'd0);
    check("x0_srcb", SrcB, 32'd0);

    // Stall with a one-cycle WB forward on rs2
    drive(3'b010, 5'd1, 32'd5, 5'd6, 32'h10, 5'd9, 1'b0, 32'h0);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    tick();
    check("stall_load_srcb", SrcB, 32'h10);
    out_ready = 1'b0;
    in_alu_control = 3'b011;
    fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd6; fwd_wb_data = 32'hABCD;
    #1;
    check("stall_fwd_srcb", SrcB, 32'hABCD);
    check("stall_in_ready0", {31'b0, in_ready}, 32'd0);
    tick();
    fwd_wb_valid = 1'b0;
    #1;
    check("stall_kept_srcb", SrcB, 32'hABCD);
    check("stall_in_ready1", {31'b0, in_ready}, 32'd0);
    check("stall_aluctl", {29'b0, ALUControl}, 32'd2);
    tick();
    check("stall_kept2_srcb", SrcB, 32'hABCD);
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_in_ready2", {31'b0, in_ready}, 32'd0);

    // Flush while holding, with a new instruction offered
    flush = 1'b1;
    drive(3'b100, 5'd1, 32'd1, 5'd2, 32'd2, 5'd10, 1'b0, 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_reg_write", {31'b0, out_reg_write}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("flush_no_new", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a hold
    drive(3'b101, 5'd3, 32'h77, 5'd2, 32'd2, 5'd11, 1'b0, 32'h0);
    tick();
    in_valid = 1'b0;
    check("hold_out_valid", {31'b0, out_valid}, 32'd1);
    check("hold_srca", SrcA, 32'h77);
    check("hold_aluctl", {29'b0, ALUControl}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_srca", SrcA, 32'd0);
    check("arst_rd", {27'b0, out_rd_addr}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
